// File: rtl/reservation_station_pkg.sv
// Shared constants and types for the ALU reservation station.
package reservation_station_pkg;

  localparam int RS_SIZE  = 8;
  localparam int RS_BIT   = 3;
  localparam int ROB_BIT  = 4;
  localparam int OP_WIDTH = 5;
  localparam int XLEN     = 32;

  localparam logic [OP_WIDTH-1:0] ALU_ADD  = 5'd0;
  localparam logic [OP_WIDTH-1:0] ALU_SUB  = 5'd1;
  localparam logic [OP_WIDTH-1:0] ALU_AND  = 5'd2;
  localparam logic [OP_WIDTH-1:0] ALU_OR   = 5'd3;
  localparam logic [OP_WIDTH-1:0] ALU_XOR  = 5'd4;
  localparam logic [OP_WIDTH-1:0] ALU_SLL  = 5'd5;
  localparam logic [OP_WIDTH-1:0] ALU_SRL  = 5'd6;
  localparam logic [OP_WIDTH-1:0] ALU_SRA  = 5'd7;
  localparam logic [OP_WIDTH-1:0] ALU_SLT  = 5'd8;
  localparam logic [OP_WIDTH-1:0] ALU_SLTU = 5'd9;

  // One waiting instruction; vj/vk are only meaningful once has_q* is clear.
  typedef struct packed {
    logic [OP_WIDTH-1:0] op;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     vj;
    logic [XLEN-1:0]     vk;
    logic                has_qj;
    logic                has_qk;
    logic [ROB_BIT-1:0]  qj;
    logic [ROB_BIT-1:0]  qk;
    logic [ROB_BIT-1:0]  rob_id;
  } rs_entry_t;

  // True when a valid broadcast carries the tag an operand is waiting on.
  function automatic logic cdb_hit(input logic valid, input logic [ROB_BIT-1:0] tag,
                                   input logic [ROB_BIT-1:0] q);
    return valid && (tag == q);
  endfunction

endpackage

// File: rtl/reservation_station_chooser.sv
// Lowest-index priority picks: first prepared entry for dispatch and first
// free entry for issue.
module reservation_station_chooser
  import reservation_station_pkg::*;
(
  input  logic [RS_SIZE-1:0] busy_i,
  input  logic [RS_SIZE-1:0] prepared_i,
  output logic [RS_BIT-1:0]  rs_entry_o,
  output logic               ready_o,
  output logic [RS_BIT-1:0]  issue_entry_o,
  output logic               full_o
);

  // Scan from the top down so the lowest matching index is the one that sticks.
  always_comb begin
    rs_entry_o    = '0;
    ready_o       = 1'b0;
    issue_entry_o = '0;
    full_o        = 1'b1;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (prepared_i[i]) begin
        rs_entry_o = RS_BIT'(i);
        ready_o    = 1'b1;
      end
      if (!busy_i[i]) begin
        issue_entry_o = RS_BIT'(i);
        full_o        = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: buffers issued instructions, captures operands
// from the two CDB ports, and hands one operand-complete entry per cycle to
// the ALU.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                clear_in,
  input  logic                issue_valid,
  input  logic [OP_WIDTH-1:0] issue_op,
  input  logic [XLEN-1:0]     issue_pc,
  input  logic [XLEN-1:0]     issue_vj,
  input  logic [XLEN-1:0]     issue_vk,
  input  logic                issue_has_qj,
  input  logic                issue_has_qk,
  input  logic [ROB_BIT-1:0]  issue_qj,
  input  logic [ROB_BIT-1:0]  issue_qk,
  input  logic [ROB_BIT-1:0]  issue_rob_id,
  output logic                full_out,
  input  logic                cdb0_valid,
  input  logic [ROB_BIT-1:0]  cdb0_rob_id,
  input  logic [XLEN-1:0]     cdb0_value,
  input  logic                cdb1_valid,
  input  logic [ROB_BIT-1:0]  cdb1_rob_id,
  input  logic [XLEN-1:0]     cdb1_value,
  output logic                alu_valid,
  output logic [OP_WIDTH-1:0] alu_op,
  output logic [XLEN-1:0]     alu_v1,
  output logic [XLEN-1:0]     alu_v2,
  output logic [XLEN-1:0]     alu_pc,
  output logic [ROB_BIT-1:0]  alu_rob_id
);

  logic [RS_SIZE-1:0]  busy_q, busy_d;
  rs_entry_t           ent_q [RS_SIZE];
  rs_entry_t           ent_d [RS_SIZE];
  rs_entry_t           new_ent;
  logic [RS_SIZE-1:0]  prepared;
  logic [RS_BIT-1:0]   rs_entry, issue_entry;
  logic                ready, full;

  logic                alu_valid_q, alu_valid_d;
  logic [OP_WIDTH-1:0] alu_op_q, alu_op_d;
  logic [XLEN-1:0]     alu_v1_q, alu_v1_d, alu_v2_q, alu_v2_d, alu_pc_q, alu_pc_d;
  logic [ROB_BIT-1:0]  alu_rob_id_q, alu_rob_id_d;

  // An entry may dispatch once it holds both operand values.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++)
      prepared[i] = busy_q[i] && !ent_q[i].has_qj && !ent_q[i].has_qk;
  end

  reservation_station_chooser u_chooser (
    .busy_i        (busy_q),
    .prepared_i    (prepared),
    .rs_entry_o    (rs_entry),
    .ready_o       (ready),
    .issue_entry_o (issue_entry),
    .full_o        (full)
  );

  assign full_out = full;

  // Incoming instruction with same-cycle CDB forwarding; cdb0 wins a double hit.
  always_comb begin
    new_ent.op     = issue_op;
    new_ent.pc     = issue_pc;
    new_ent.vj     = issue_vj;
    new_ent.vk     = issue_vk;
    new_ent.has_qj = issue_has_qj;
    new_ent.has_qk = issue_has_qk;
    new_ent.qj     = issue_qj;
    new_ent.qk     = issue_qk;
    new_ent.rob_id = issue_rob_id;
    if (issue_has_qj && cdb_hit(cdb0_valid, cdb0_rob_id, issue_qj)) begin
      new_ent.vj = cdb0_value; new_ent.has_qj = 1'b0;
    end else if (issue_has_qj && cdb_hit(cdb1_valid, cdb1_rob_id, issue_qj)) begin
      new_ent.vj = cdb1_value; new_ent.has_qj = 1'b0;
    end
    if (issue_has_qk && cdb_hit(cdb0_valid, cdb0_rob_id, issue_qk)) begin
      new_ent.vk = cdb0_value; new_ent.has_qk = 1'b0;
    end else if (issue_has_qk && cdb_hit(cdb1_valid, cdb1_rob_id, issue_qk)) begin
      new_ent.vk = cdb1_value; new_ent.has_qk = 1'b0;
    end
  end

  // Next state: flush, pause, or wakeup + issue + dispatch on disjoint entries.
  always_comb begin
    busy_d       = busy_q;
    ent_d        = ent_q;
    alu_valid_d  = 1'b0;
    alu_op_d     = alu_op_q;
    alu_v1_d     = alu_v1_q;
    alu_v2_d     = alu_v2_q;
    alu_pc_d     = alu_pc_q;
    alu_rob_id_d = alu_rob_id_q;
    if (clear_in) begin
      busy_d = '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i] && ent_q[i].has_qj) begin
          if (cdb_hit(cdb0_valid, cdb0_rob_id, ent_q[i].qj)) begin
            ent_d[i].vj = cdb0_value; ent_d[i].has_qj = 1'b0;
          end else if (cdb_hit(cdb1_valid, cdb1_rob_id, ent_q[i].qj)) begin
            ent_d[i].vj = cdb1_value; ent_d[i].has_qj = 1'b0;
          end
        end
        if (busy_q[i] && ent_q[i].has_qk) begin
          if (cdb_hit(cdb0_valid, cdb0_rob_id, ent_q[i].qk)) begin
            ent_d[i].vk = cdb0_value; ent_d[i].has_qk = 1'b0;
          end else if (cdb_hit(cdb1_valid, cdb1_rob_id, ent_q[i].qk)) begin
            ent_d[i].vk = cdb1_value; ent_d[i].has_qk = 1'b0;
          end
        end
      end
      if (issue_valid && !full) begin
        ent_d[issue_entry]  = new_ent;
        busy_d[issue_entry] = 1'b1;
      end
      if (ready) begin
        alu_valid_d      = 1'b1;
        alu_op_d         = ent_q[rs_entry].op;
        alu_v1_d         = ent_q[rs_entry].vj;
        alu_v2_d         = ent_q[rs_entry].vk;
        alu_pc_d         = ent_q[rs_entry].pc;
        alu_rob_id_d     = ent_q[rs_entry].rob_id;
        busy_d[rs_entry] = 1'b0;
      end
    end
  end

  // Control state and ALU outputs, cleared by reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q       <= '0;
      alu_valid_q  <= 1'b0;
      alu_op_q     <= '0;
      alu_v1_q     <= '0;
      alu_v2_q     <= '0;
      alu_pc_q     <= '0;
      alu_rob_id_q <= '0;
    end else begin
      busy_q       <= busy_d;
      alu_valid_q  <= alu_valid_d;
      alu_op_q     <= alu_op_d;
      alu_v1_q     <= alu_v1_d;
      alu_v2_q     <= alu_v2_d;
      alu_pc_q     <= alu_pc_d;
      alu_rob_id_q <= alu_rob_id_d;
    end
  end

  // Entry payloads are qualified by busy, so they need no reset.
  always_ff @(posedge clk_in) begin
    ent_q <= ent_d;
  end

  assign alu_valid  = alu_valid_q;
  assign alu_op     = alu_op_q;
  assign alu_v1     = alu_v1_q;
  assign alu_v2     = alu_v2_q;
  assign alu_pc     = alu_pc_q;
  assign alu_rob_id = alu_rob_id_q;

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: a slot-level reference model
// predicts every ALU dispatch; a negedge monitor compares.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic                rst_in, rdy_in, clear_in, issue_valid;
  logic [OP_WIDTH-1:0] issue_op;
  logic [XLEN-1:0]     issue_pc, issue_vj, issue_vk;
  logic                issue_has_qj, issue_has_qk;
  logic [ROB_BIT-1:0]  issue_qj, issue_qk, issue_rob_id;
  logic                full_out;
  logic                cdb0_valid, cdb1_valid;
  logic [ROB_BIT-1:0]  cdb0_rob_id, cdb1_rob_id;
  logic [XLEN-1:0]     cdb0_value, cdb1_value;
  logic                alu_valid;
  logic [OP_WIDTH-1:0] alu_op;
  logic [XLEN-1:0]     alu_v1, alu_v2, alu_pc;
  logic [ROB_BIT-1:0]  alu_rob_id;

  reservation_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_pc(issue_pc),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_has_qj(issue_has_qj), .issue_has_qk(issue_has_qk),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_rob_id(issue_rob_id),
    .full_out(full_out),
    .cdb0_valid(cdb0_valid), .cdb0_rob_id(cdb0_rob_id), .cdb0_value(cdb0_value),
    .cdb1_valid(cdb1_valid), .cdb1_rob_id(cdb1_rob_id), .cdb1_value(cdb1_value),
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_v1(alu_v1), .alu_v2(alu_v2),
    .alu_pc(alu_pc), .alu_rob_id(alu_rob_id)
  );

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  // Reference slot: a pending operand is a tag >= 0, a resolved one is -1.
  typedef struct {
    bit                  busy;
    logic [OP_WIDTH-1:0] op;
    logic [XLEN-1:0]     pc, vj, vk;
    int                  tj, tk;
    logic [ROB_BIT-1:0]  rob;
  } slot_t;
  slot_t m[RS_SIZE];

  typedef struct packed {
    logic [OP_WIDTH-1:0] op;
    logic [XLEN-1:0]     pc, v1, v2;
    logic [ROB_BIT-1:0]  rob;
  } exp_t;
  exp_t exp_q[$];

  function automatic bit model_full();
    for (int i = 0; i < RS_SIZE; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wake(inout int t, inout logic [XLEN-1:0] v);
    if (t < 0) return;
    if (cdb0_valid && int'(cdb0_rob_id) == t) begin v = cdb0_value; t = -1; end
    else if (cdb1_valid && int'(cdb1_rob_id) == t) begin v = cdb1_value; t = -1; end
  endtask

  // Advance the reference by one clock edge using the inputs about to be sampled.
  task automatic model_step();
    int ri, fi, t;
    logic [XLEN-1:0] v;
    slot_t n;
    exp_t e;
    if (rst_in || clear_in) begin
      for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
      return;
    end
    if (!rdy_in) return;
    ri = -1; fi = -1;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ri < 0 && m[i].busy && m[i].tj < 0 && m[i].tk < 0) ri = i;
      if (fi < 0 && !m[i].busy) fi = i;
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      if (m[i].busy) begin
        t = m[i].tj; v = m[i].vj; wake(t, v); m[i].tj = t; m[i].vj = v;
        t = m[i].tk; v = m[i].vk; wake(t, v); m[i].tk = t; m[i].vk = v;
      end
    end
    if (issue_valid && fi >= 0) begin
      n.busy = 1'b1; n.op = issue_op; n.pc = issue_pc; n.rob = issue_rob_id;
      t = issue_has_qj ? int'(issue_qj) : -1; v = issue_vj; wake(t, v); n.tj = t; n.vj = v;
      t = issue_has_qk ? int'(issue_qk) : -1; v = issue_vk; wake(t, v); n.tk = t; n.vk = v;
      m[fi] = n;
    end
    if (ri >= 0) begin
      e.op = m[ri].op; e.pc = m[ri].pc; e.v1 = m[ri].vj; e.v2 = m[ri].vk; e.rob = m[ri].rob;
      exp_q.push_back(e);
      m[ri].busy = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; clear_in = 1'b0; rdy_in = 1'b1;
    cdb0_valid = 1'b0; cdb1_valid = 1'b0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_in);
    @(negedge clk_in);
    #1;
    idle_inputs();
  endtask

  task automatic issue(input logic [OP_WIDTH-1:0] op, input logic [XLEN-1:0] pc,
                       input logic [XLEN-1:0] vj, input logic [XLEN-1:0] vk,
                       input logic hqj, input logic [ROB_BIT-1:0] qj,
                       input logic hqk, input logic [ROB_BIT-1:0] qk,
                       input logic [ROB_BIT-1:0] rob);
    issue_valid = 1'b1; issue_op = op; issue_pc = pc; issue_vj = vj; issue_vk = vk;
    issue_has_qj = hqj; issue_qj = qj; issue_has_qk = hqk; issue_qk = qk;
    issue_rob_id = rob;
  endtask

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every cycle, occupancy and any dispatch must match the reference.
  always @(negedge clk_in) begin
    exp_t e;
    if (mon_en) begin
      checks++;
      if (full_out !== model_full()) begin
        failures++;
        $display("FAIL full_out actual=%0b required=%0b", full_out, model_full());
      end
      checks++;
      if (alu_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_dispatch actual=rob%0d required=none", alu_rob_id);
        end else begin
          e = exp_q.pop_front();
          if (alu_op !== e.op || alu_pc !== e.pc || alu_v1 !== e.v1 ||
              alu_v2 !== e.v2 || alu_rob_id !== e.rob) begin
            failures++;
            $display("FAIL dispatch actual=op%0h pc%0h v1=%0h v2=%0h rob%0d required=op%0h pc%0h v1=%0h v2=%0h rob%0d",
                     alu_op, alu_pc, alu_v1, alu_v2, alu_rob_id,
                     e.op, e.pc, e.v1, e.v2, e.rob);
          end
        end
      end else if (alu_valid !== 1'b0) begin
        failures++;
        $display("FAIL alu_valid actual=%b required=0/1", alu_valid);
      end else if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL missing_dispatch actual=none required=rob%0d", exp_q[0].rob);
        exp_q.delete();
      end
    end
  end

  initial begin
    for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
    rst_in = 1'b1;
    idle_inputs();
    issue_valid = 1'b0;
    issue('0, '0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
    issue_valid = 1'b0;
    cdb0_rob_id = '0; cdb1_rob_id = '0; cdb0_value = '0; cdb1_value = '0;
    @(negedge clk_in); #1;
    tick();
    tick();
    check("rst_alu_valid", XLEN'(alu_valid), 0);
    check("rst_alu_op", XLEN'(alu_op), 0);
    check("rst_alu_v1", alu_v1, 0);
    check("rst_alu_v2", alu_v2, 0);
    check("rst_alu_pc", alu_pc, 0);
    check("rst_alu_rob_id", XLEN'(alu_rob_id), 0);
    check("rst_full_out", XLEN'(full_out), 0);
    rst_in = 1'b0;
    mon_en = 1'b1;

    // Ready operands: dispatch two edges after issue.
    issue(ALU_ADD, 32'h100, 5, 7, 1'b0, 0, 1'b0, 0, 3);
    tick(); tick(); tick();

    // Pending qj woken by cdb1.
    issue(ALU_SUB, 32'h104, 0, 11, 1'b1, 2, 1'b0, 0, 5);
    tick(); tick(); tick();
    cdb1_valid = 1'b1; cdb1_rob_id = 2; cdb1_value = 32'h1234;
    tick(); tick(); tick();

    // Same-cycle forwarding of qk from cdb0.
    issue(ALU_OR, 32'h108, 21, 0, 1'b0, 0, 1'b1, 4, 6);
    cdb0_valid = 1'b1; cdb0_rob_id = 4; cdb0_value = 9;
    tick(); tick(); tick();

    // Fill all slots on tag 1, a ninth issue is dropped, then one broadcast.
    for (int i = 0; i < RS_SIZE; i++) begin
      issue(ALU_XOR, 32'h200 + 4 * i, 0, 32'(i), 1'b1, 1, 1'b0, 0, ROB_BIT'(8 + i));
      tick();
    end
    check("full_after_8", XLEN'(full_out), 1);
    issue(ALU_AND, 32'h2ff, 1, 1, 1'b0, 0, 1'b0, 0, 15);
    tick();
    cdb0_valid = 1'b1; cdb0_rob_id = 1; cdb0_value = 32'hbeef;
    tick();
    for (int i = 0; i < RS_SIZE + 2; i++) tick();

    // Flush with issue and broadcast in the same cycle.
    issue(ALU_ADD, 32'h300, 0, 0, 1'b1, 9, 1'b0, 0, 1); tick();
    issue(ALU_ADD, 32'h304, 0, 0, 1'b0, 0, 1'b1, 9, 2); tick();
    issue(ALU_ADD, 32'h308, 1, 2, 1'b0, 0, 1'b0, 0, 3); tick();
    clear_in = 1'b1;
    issue(ALU_SLT, 32'h30c, 4, 4, 1'b0, 0, 1'b0, 0, 4);
    cdb0_valid = 1'b1; cdb0_rob_id = 9; cdb0_value = 77;
    tick();
    check("clear_full_out", XLEN'(full_out), 0);
    check("clear_alu_valid", XLEN'(alu_valid), 0);
    cdb0_valid = 1'b1; cdb0_rob_id = 9; cdb0_value = 78;
    tick(); tick(); tick();

    // Pause holds a ready entry, dispatch follows resumption.
    issue(ALU_SLL, 32'h400, 3, 2, 1'b0, 0, 1'b0, 0, 7);
    tick();
    for (int i = 0; i < 3; i++) begin rdy_in = 1'b0; tick(); end
    tick(); tick();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) < 2) clear_in = 1'b1;
      rdy_in = ($urandom_range(0, 9) != 0);
      if (!model_full() && $urandom_range(0, 1) == 1)
        issue(OP_WIDTH'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
              1'($urandom_range(0, 1)), ROB_BIT'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), ROB_BIT'($urandom_range(0, 3)),
              ROB_BIT'($urandom_range(0, 15)));
      cdb0_valid = ($urandom_range(0, 2) == 0);
      cdb0_rob_id = ROB_BIT'($urandom_range(0, 3)); cdb0_value = $urandom;
      cdb1_valid = ($urandom_range(0, 2) == 0);
      cdb1_rob_id = ROB_BIT'($urandom_range(0, 3)); cdb1_value = $urandom;
      tick();
    end
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
